// File: rtl/serial_tx.sv
// serial_tx -- parallel-in, serial-out transmitter for the shift-register
// serial link. Accepts WIDTH-bit words on a valid/ready handshake, keeps one
// word in a holding buffer, and shifts each word out one bit per `en` strobe
// with first/last framing flags. Back-to-back frames are gapless when the
// buffer is refilled before the current frame ends.
//
// Optional feature: define SERIAL_TX_PARITY_EN to append an even-parity bit
// (XOR of the data bits) after each word; that bit then carries so_last.
//
// Ports:
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   en         bit-rate strobe; serial state advances only when high
//   dir        bit order for the word being accepted (1 = LSB first)
//   din_valid  producer has a word on din
//   din        parallel data word
//   din_ready  holding buffer empty (accept on din_valid && din_ready)
//   so         serial data bit
//   so_valid   so carries a frame bit
//   so_first   so is the first bit of a frame
//   so_last    so is the last bit of a frame
//   busy       holding buffer full or frame in progress
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | no frame on the line; waits for an en strobe with a buffered word
// DATA   | data bits on so; cnt holds the number of bits already driven
// PARITY | parity bit on so (only with SERIAL_TX_PARITY_EN)

module serial_tx #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             dir,
   input  logic             din_valid,
   input  logic [WIDTH-1:0] din,
   output logic             din_ready,
   output logic             so,
   output logic             so_valid,
   output logic             so_first,
   output logic             so_last,
   output logic             busy
);

   localparam int CW = $clog2(WIDTH + 2);
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH);
   localparam logic [CW-1:0] CNT_PEN  = CW'(WIDTH - 1);

`ifdef SERIAL_TX_PARITY_EN
   typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY} state_t;
`else
   typedef enum logic [1:0] {S_IDLE, S_DATA} state_t;
`endif

   state_t            state_q, state_d;
   logic [WIDTH-1:0]  buf_data_q, buf_data_d;
   logic              buf_dir_q, buf_dir_d;
   logic              buf_full_q, buf_full_d;
   logic [WIDTH-1:0]  sh_q, sh_d;
   logic              fdir_q, fdir_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic              so_q, so_d;
   logic              so_valid_q, so_valid_d;
   logic              so_first_q, so_first_d;
   logic              so_last_q, so_last_d;
`ifdef SERIAL_TX_PARITY_EN
   logic              par_q, par_d;
`endif

   logic              accept;
   logic              load;
   logic              end_frame;

   assign din_ready = !buf_full_q;
   assign accept    = din_valid && !buf_full_q;
   assign busy      = (state_q != S_IDLE) || buf_full_q;

   assign so        = so_q;
   assign so_valid  = so_valid_q;
   assign so_first  = so_first_q;
   assign so_last   = so_last_q;

   always_comb begin
      state_d    = state_q;
      buf_data_d = buf_data_q;
      buf_dir_d  = buf_dir_q;
      buf_full_d = buf_full_q;
      sh_d       = sh_q;
      fdir_d     = fdir_q;
      cnt_d      = cnt_q;
      so_d       = so_q;
      so_valid_d = so_valid_q;
      so_first_d = so_first_q;
      so_last_d  = so_last_q;
`ifdef SERIAL_TX_PARITY_EN
      par_d      = par_q;
`endif
      load       = 1'b0;
      end_frame  = 1'b0;

      if (en) begin
         case (state_q)
            S_IDLE: begin
               load = buf_full_q;
            end
            S_DATA: begin
               if (cnt_q < CNT_LAST) begin
                  // shifter already has the driven bit removed, so the next
                  // bit always sits at the exit end for the latched order
                  so_d       = fdir_q ? sh_q[0] : sh_q[WIDTH-1];
                  sh_d       = fdir_q ? (sh_q >> 1) : (sh_q << 1);
                  cnt_d      = cnt_q + 1'b1;
                  so_first_d = 1'b0;
`ifdef SERIAL_TX_PARITY_EN
                  so_last_d  = 1'b0;
`else
                  so_last_d  = (cnt_q == CNT_PEN);
`endif
               end else begin
`ifdef SERIAL_TX_PARITY_EN
                  state_d    = S_PARITY;
                  so_d       = par_q;
                  so_first_d = 1'b0;
                  so_last_d  = 1'b1;
`else
                  end_frame  = 1'b1;
`endif
               end
            end
`ifdef SERIAL_TX_PARITY_EN
            S_PARITY: begin
               end_frame = 1'b1;
            end
`endif
            default: begin
               state_d = S_IDLE;
            end
         endcase

         if (end_frame) begin
            if (buf_full_q) begin
               load = 1'b1;
            end else begin
               state_d    = S_IDLE;
               so_d       = 1'b0;
               so_valid_d = 1'b0;
               so_first_d = 1'b0;
               so_last_d  = 1'b0;
            end
         end

         if (load) begin
            state_d    = S_DATA;
            so_d       = buf_dir_q ? buf_data_q[0] : buf_data_q[WIDTH-1];
            sh_d       = buf_dir_q ? (buf_data_q >> 1) : (buf_data_q << 1);
            fdir_d     = buf_dir_q;
            cnt_d      = CW'(1);
            so_valid_d = 1'b1;
            so_first_d = 1'b1;
            so_last_d  = 1'b0;
            buf_full_d = 1'b0;
`ifdef SERIAL_TX_PARITY_EN
            par_d      = ^buf_data_q;
`endif
         end
      end

      // accept needs an empty buffer and load needs a full one, so the two
      // never collide on the same edge
      if (accept) begin
         buf_data_d = din;
         buf_dir_d  = dir;
         buf_full_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         buf_data_q <= '0;
         buf_dir_q  <= 1'b0;
         buf_full_q <= 1'b0;
         sh_q       <= '0;
         fdir_q     <= 1'b0;
         cnt_q      <= '0;
         so_q       <= 1'b0;
         so_valid_q <= 1'b0;
         so_first_q <= 1'b0;
         so_last_q  <= 1'b0;
`ifdef SERIAL_TX_PARITY_EN
         par_q      <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         buf_data_q <= buf_data_d;
         buf_dir_q  <= buf_dir_d;
         buf_full_q <= buf_full_d;
         sh_q       <= sh_d;
         fdir_q     <= fdir_d;
         cnt_q      <= cnt_d;
         so_q       <= so_d;
         so_valid_q <= so_valid_d;
         so_first_q <= so_first_d;
         so_last_q  <= so_last_d;
`ifdef SERIAL_TX_PARITY_EN
         par_q      <= par_d;
`endif
      end
   end

endmodule

// File: tb/tb_serial_tx.sv
// Testbench for serial_tx: directed words with hand-written transmission
// sequences; expected bits and words are queued when a word is issued and a
// monitor pops and compares them as the DUT presents each frame bit.
module tb_serial_tx;

   localparam int W = 8;
`ifdef SERIAL_TX_PARITY_EN
   localparam int FL = W + 1;
`else
   localparam int FL = W;
`endif

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         en = 1'b0;
   logic         dir = 1'b0;
   logic         din_valid = 1'b0;
   logic [W-1:0] din = '0;
   logic         din_ready, so, so_valid, so_first, so_last, busy;

   serial_tx #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (en),
      .dir       (dir),
      .din_valid (din_valid),
      .din       (din),
      .din_ready (din_ready),
      .so        (so),
      .so_valid  (so_valid),
      .so_first  (so_first),
      .so_last   (so_last),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   typedef struct packed {logic b; logic f; logic l;} bit_t;
   typedef struct packed {logic [W-1:0] w; logic d;} word_t;

   bit_t  exp_q[$];
   word_t wq[$];

   int n_chk = 0;
   int n_pass = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_chk++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
   endtask

   // en generator: high one cycle in every en_div
   int en_div = 1;
   int cyc = 0;
   initial begin
      forever begin
         @(posedge clk);
         #1;
         cyc++;
         en = ((cyc % en_div) == 0);
      end
   end

   // monitor / receiver
   int           idx = 0;
   logic         cur_d = 1'b0;
   logic [W-1:0] rx = '0;
   logic [W-1:0] r;
   word_t        cw;
   bit_t         e;
   int           vrun = 0;
   int           vmax = 0;
   logic         prev_en = 1'b0;
   logic         prev_rst = 1'b0;
   logic [3:0]   prev_out = '0;

   always @(negedge clk) begin
      if (rst_n) begin
         if (!prev_en && prev_rst)
            chk("hold_no_en", {28'd0, so, so_valid, so_first, so_last}, {28'd0, prev_out});
         if (so_valid) vrun++;
         else vrun = 0;
         if (vrun > vmax) vmax = vrun;
         if (en && so_valid) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_bit", 32'd1, 32'd0);
            end else begin
               e = exp_q.pop_front();
               chk("so", {31'd0, so}, {31'd0, e.b});
               chk("so_first", {31'd0, so_first}, {31'd0, e.f});
               chk("so_last", {31'd0, so_last}, {31'd0, e.l});
            end
            if (so_first) begin
               idx = 0;
               if (wq.size() > 0) cur_d = wq[0].d;
            end
            if (idx < W) begin
               r = cur_d ? {so, rx[W-1:1]} : {rx[W-2:0], so};
               rx = r;
               if (idx == W - 1) begin
                  if (wq.size() == 0) chk("unexpected_word", 32'd1, 32'd0);
                  else begin
                     cw = wq.pop_front();
                     chk("loopback_word", {24'd0, rx}, {24'd0, cw.w});
                  end
               end
            end
            idx++;
         end
      end
      prev_en  = en;
      prev_rst = rst_n;
      prev_out = {so, so_valid, so_first, so_last};
   end

   // seq: transmission order, first bit in seq[W-1]
   task automatic send(input logic [W-1:0] w, input logic d,
                       input logic [W-1:0] seq, input logic par);
      int t;
      t = 0;
      while (!din_ready && t < 400) begin
         @(posedge clk);
         #1;
         t++;
      end
      if (!din_ready) chk("ready_timeout", 32'd0, 32'd1);
      for (int i = 0; i < W; i++)
         exp_q.push_back('{b: seq[W-1-i], f: (i == 0), l: ((i == W - 1) && (FL == W))});
`ifdef SERIAL_TX_PARITY_EN
      exp_q.push_back('{b: par, f: 1'b0, l: 1'b1});
`else
      if (par === 1'bx) chk("par_x", 32'd0, 32'd1);
`endif
      wq.push_back('{w: w, d: d});
      din = w;
      dir = d;
      din_valid = 1'b1;
      @(posedge clk);
      #1;
      din_valid = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      int t;
      t = 0;
      while ((busy || exp_q.size() != 0) && t < 1000) begin
         @(posedge clk);
         #1;
         t++;
      end
      chk(name, {31'd0, busy}, 32'd0);
      chk({name, "_drained"}, exp_q.size(), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(posedge clk);
      #1;
      chk("rst_so_valid", {31'd0, so_valid}, 32'd0);
      chk("rst_so", {31'd0, so}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_din_ready", {31'd0, din_ready}, 32'd1);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // 0xA5 LSB first, latency and buffer flag
      send(8'hA5, 1'b1, 8'hA5, 1'b0);
      chk("lat_no_bit_at_accept", {31'd0, so_valid}, 32'd0);
      chk("ready_low_full", {31'd0, din_ready}, 32'd0);
      chk("busy_full", {31'd0, busy}, 32'd1);
      @(posedge clk);
      #1;
      chk("lat_first_bit", {30'd0, so_valid, so_first}, 32'd3);
      chk("ready_after_load", {31'd0, din_ready}, 32'd1);
      wait_idle("a5_lsb_idle");
      chk("a5_valid_dropped", {31'd0, so_valid}, 32'd0);

      // 0xA5 MSB first
      send(8'hA5, 1'b0, 8'hA5, 1'b0);
      wait_idle("a5_msb_idle");

      // back-to-back stream
      vmax = 0;
      send(8'h01, 1'b0, 8'h01, 1'b1);
      send(8'h80, 1'b0, 8'h80, 1'b1);
      chk("ready_low_second", {31'd0, din_ready}, 32'd0);
      send(8'hFF, 1'b0, 8'hFF, 1'b0);
      wait_idle("stream_idle");
      chk("stream_contiguous", vmax, 3 * FL);

      // bit order reversal cases
      send(8'h01, 1'b1, 8'h80, 1'b1);
      send(8'h80, 1'b1, 8'h01, 1'b1);
      wait_idle("order_idle");

      // en 1-in-4, dir toggled mid-frame
      en_div = 4;
      send(8'h3C, 1'b1, 8'h3C, 1'b0);
      repeat (9) @(posedge clk);
      #1;
      dir = 1'b0;
      wait_idle("pulse_3c_idle");
      send(8'h0B, 1'b1, 8'hD0, 1'b1);
      repeat (10) @(posedge clk);
      #1;
      dir = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      dir = 1'b1;
      wait_idle("pulse_0b_idle");
      en_div = 1;
      @(posedge clk);
      #1;

      // parity cases (plain frames without the macro)
      send(8'h07, 1'b1, 8'hE0, 1'b1);
      send(8'h03, 1'b0, 8'h03, 1'b0);
      wait_idle("parity_idle");

      // reset mid-frame with a second word buffered
      send(8'hA5, 1'b1, 8'hA5, 1'b0);
      send(8'h5A, 1'b1, 8'h5A, 1'b0);
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_outs", {28'd0, so, so_valid, so_first, so_last}, 32'd0);
      chk("mid_rst_busy", {31'd0, busy}, 32'd0);
      chk("mid_rst_ready", {31'd0, din_ready}, 32'd1);
      exp_q.delete();
      wq.delete();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("post_rst_no_frame", {31'd0, so_valid}, 32'd0);
      chk("post_rst_busy", {31'd0, busy}, 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/serial_tx.md
# serial_tx

Parallel-in, serial-out transmitter: the driving end of the shift-register serial link. Accepts WIDTH-bit words over a valid/ready handshake, buffers one word, and emits each word one bit per bit-enable strobe on `so`, with framing flags, so that a downstream shift register clocked by the same `en` reconstructs the word exactly. Sits between a word-oriented producer (FIFO, register file) and a serial link.

## Interface
- `WIDTH`, 8, data word width; legal range ≥ 2.
- `clk`  in  1  clock; all logic on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `en`  in  1  bit-rate strobe; serial state advances only on edges where `en`=1.
- `dir`  in  1  bit order for the word being loaded: 1 = LSB first, 0 = MSB first.
- `din_valid`  in  1  producer has a word on `din`.
- `din`  in  WIDTH  parallel data word.
- `din_ready`  out  1  holding buffer empty; transfer occurs on an edge with `din_valid && din_ready`.
- `so`  out  1  serial data bit, registered.
- `so_valid`  out  1  `so` carries a frame bit, registered.
- `so_first`  out  1  `so` is the first bit of a frame.
- `so_last`  out  1  `so` is the last bit of a frame.
- `busy`  out  1  holding buffer full or frame in progress.

## Operation
- Datapath: one-word holding buffer (`buf`, `buf_full`, latched `dir`), WIDTH-bit shifter, bit counter of `$clog2(WIDTH+2)` bits, FSM.
- `din_ready` = `!buf_full` (combinational from the flag, no path from `din_valid`). Accept writes `din` and `dir` into the buffer and sets `buf_full`, independent of `en`.
- FSM states: IDLE, DATA, PARITY (PARITY only with the macro defined).
- IDLE, `en`=1, `buf_full`: load shifter from buffer, clear `buf_full`, drive first bit (`din[0]` if latched dir=1, else `din[WIDTH-1]`), `so_valid`=1, `so_first`=1, counter=1, go to DATA.
- DATA, `en`=1, counter<WIDTH: drive next bit in latched order, `so_first`=0, counter+1; `so_last`=1 on bit WIDTH when parity is compiled out.
- DATA, `en`=1, counter==WIDTH: with the macro, go to PARITY and drive the parity bit with `so_last`=1; without it, end the frame.
- End of frame (`en` edge after the last bit): if `buf_full`, load and drive the next word's first bit in the same edge (no gap); else `so_valid`=0, `so_first`=0, `so_last`=0, go to IDLE.
- `dir` is sampled only at accept; changes mid-frame do not affect the frame in progress.
- Non-`en` edges: `so`, `so_valid`, `so_first`, `so_last`, shifter, counter, and state hold.
- `busy` = (state != IDLE) || `buf_full`.
- Reset (any time, including mid-frame): state IDLE, `buf_full`=0 (buffered word discarded), `so`=0, `so_valid`=0, `so_first`=0, `so_last`=0, `busy`=0, `din_ready`=1.

## Timing
- Serial outputs change only on `en` edges. Receiver samples `so` on the next edge with `en && so_valid`.
- A receiver shift register with `si`=`so`, matching `dir`, and enable = `en && so_valid` holds the word after the `so_last` bit is sampled.
- Accept-to-first-bit latency: first `en` edge strictly after the accept edge. With `en` held at 1: accept at edge N, first bit at edge N+1.
- Frame length: WIDTH `en` strobes, or WIDTH+1 with parity.
- Buffer frees at frame load. `din_ready` rises the cycle after load; a new word can be accepted during any bit of the current frame.
- With `en`=1 continuously and the producer always valid, frames run back-to-back with `so_valid` never deasserting.

## Configuration
- `SERIAL_TX_PARITY_EN` defined: PARITY state present; an even-parity bit (XOR of the WIDTH data bits) follows each word as bit WIDTH+1 and carries `so_last`.
- Not defined: no PARITY state; `so_last` is on data bit WIDTH; frame is exactly WIDTH bits.

## Test plan
- Reset, WIDTH=8, `en`=1, accept 0xA5 with `dir`=1 → `so` = 1,0,1,0,0,1,0,1 on edges N+1..N+8; `so_first` only on the first bit, `so_last` only on the last (without macro); `so_valid`=0 at N+9.
- Accept 0xA5 with `dir`=0 → `so` = 1,0,1,0,0,1,0,1 MSB-first (bit7..bit0); loopback into a shift register with `dir`=0 reads 0xA5.
- Stream 0x01, 0x80, 0xFF back-to-back, `en`=1 → 24 contiguous `so_valid` cycles with no gaps; `din_ready` low while the buffer is full; loopback reads all three words.
- `en` pulsing 1-in-4 with 0x3C → each bit held 4 cycles; `so_valid` and the bit values change only on `en` edges; `dir` toggled mid-frame has no effect.
- Assert `rst_n`=0 at bit 4 with a second word buffered → all outputs 0 immediately, `din_ready`=1, `busy`=0; after release, next `en` with no accept leaves `so_valid`=0.
- With `SERIAL_TX_PARITY_EN`: 0x07 → 9-bit frame with parity bit 1 carrying `so_last`; 0x03 → parity bit 0.
